// File: rtl/mvu_pkg.sv
// Shared types and default widths for the MVU job controller.
// Imported by mvu_job_ctrl and mvu_loop_cnt.
package mvu_pkg;

  localparam int unsigned DEF_BWBANKA = 9;
  localparam int unsigned DEF_BDBANKA = 14;
  localparam int unsigned DEF_BLEN    = 10;
  localparam int unsigned DEF_BPREC   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mvu_loop_cnt.sv
// Loadable wrapping counter with terminal-count flag.
// One instance per loop level of the MVU issue sequence.
module mvu_loop_cnt
  import mvu_pkg::*;
#(
  parameter int unsigned W = DEF_BLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == max);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mvu_job_ctrl.sv
// MVU job sequencer: issue loop, drain, result write.
// Define MVU_MAXPOOL_EN to enable the max-pool control outputs.
module mvu_job_ctrl
  import mvu_pkg::*;
#(
  parameter int unsigned BWBANKA = DEF_BWBANKA,
  parameter int unsigned BDBANKA = DEF_BDBANKA,
  parameter int unsigned BLEN    = DEF_BLEN,
  parameter int unsigned BPREC   = DEF_BPREC,
  parameter int unsigned LAT     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BPREC-1:0]   cfg_wprec,
  input  logic [BPREC-1:0]   cfg_iprec,
  input  logic [BLEN-1:0]    cfg_len,
  input  logic [BLEN-1:0]    cfg_rows,
  input  logic [BWBANKA-1:0] cfg_wbase,
  input  logic [BDBANKA-1:0] cfg_dbase,
  input  logic [BDBANKA-1:0] cfg_obase,
  input  logic               cfg_pool_en,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               acc_clr,
  output logic               acc_sh,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr,
  output logic               max_en,
  output logic               max_clr,
  output logic               max_pool,
  output logic               busy,
  output logic               done
);

  state_e state_q, state_d;

  logic [BPREC-1:0]   wprec_q, wprec_d;
  logic [BPREC-1:0]   iprec_q, iprec_d;
  logic [BLEN-1:0]    len_q, len_d;
  logic [BLEN-1:0]    rows_q, rows_d;
  logic [BDBANKA-1:0] dbase_q, dbase_d;
  logic [BDBANKA-1:0] dptr_q, dptr_d;
  logic [BDBANKA-1:0] optr_q, optr_d;
  logic [BWBANKA-1:0] wptr_q, wptr_d;
  logic [BWBANKA-1:0] wrow_q, wrow_d;
  logic [3:0]         dcnt_q, dcnt_d;

  logic             ld, issue, wr_go, first;
  logic             k_tc, ib_tc, wb_tc, o_tc;
  logic [BLEN-1:0]  k_cnt, o_cnt, len_m1, rows_m1;
  logic [BPREC-1:0] ib_cnt, wb_cnt;

  assign issue   = (state_q == ST_ISSUE) && rdd_grnt;
  assign wr_go   = (state_q == ST_WRITE) && wrd_grnt;
  assign len_m1  = len_q - BLEN'(1);
  assign rows_m1 = rows_q - BLEN'(1);
  assign first   = (k_cnt == '0) && (ib_cnt == '0) && (wb_cnt == '0);

  mvu_loop_cnt #(.W(BLEN)) u_k (
    .clk(clk), .rst_n(rst_n), .ld(ld), .ld_val('0),
    .en(issue), .max(len_m1), .cnt(k_cnt), .tc(k_tc)
  );

  mvu_loop_cnt #(.W(BPREC)) u_ib (
    .clk(clk), .rst_n(rst_n), .ld(ld), .ld_val('0),
    .en(issue && k_tc), .max(iprec_q),
    .cnt(ib_cnt), .tc(ib_tc)
  );

  mvu_loop_cnt #(.W(BPREC)) u_wb (
    .clk(clk), .rst_n(rst_n), .ld(ld), .ld_val('0),
    .en(issue && k_tc && ib_tc), .max(wprec_q),
    .cnt(wb_cnt), .tc(wb_tc)
  );

  mvu_loop_cnt #(.W(BLEN)) u_o (
    .clk(clk), .rst_n(rst_n), .ld(ld), .ld_val('0),
    .en(wr_go), .max(rows_m1), .cnt(o_cnt), .tc(o_tc)
  );

  always_comb begin
    state_d = state_q;
    wprec_d = wprec_q;
    iprec_d = iprec_q;
    len_d   = len_q;
    rows_d  = rows_q;
    dbase_d = dbase_q;
    dptr_d  = dptr_q;
    optr_d  = optr_q;
    wptr_d  = wptr_q;
    wrow_d  = wrow_q;
    dcnt_d  = dcnt_q;
    ld      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ld      = 1'b1;
          wprec_d = cfg_wprec;
          iprec_d = cfg_iprec;
          len_d   = cfg_len;
          rows_d  = cfg_rows;
          dbase_d = cfg_dbase;
          dptr_d  = cfg_dbase;
          optr_d  = cfg_obase;
          wptr_d  = cfg_wbase;
          wrow_d  = cfg_wbase;
          if (cfg_rows == '0 || cfg_len == '0)
            state_d = ST_DONE;
          else
            state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          // Weight row replays per input plane; moves on after the last one.
          if (k_tc && ib_tc) begin
            dptr_d = dbase_q;
            wptr_d = wptr_q + BWBANKA'(1);
            wrow_d = wptr_q + BWBANKA'(1);
          end else if (k_tc) begin
            dptr_d = dptr_q + BDBANKA'(1);
            wptr_d = wrow_q;
          end else begin
            dptr_d = dptr_q + BDBANKA'(1);
            wptr_d = wptr_q + BWBANKA'(1);
          end
          if (k_tc && ib_tc && wb_tc) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == 4'(LAT - 1)) begin
          dcnt_d  = '0;
          state_d = ST_WRITE;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      ST_WRITE: begin
        if (wrd_grnt) begin
          optr_d  = optr_q + BDBANKA'(1);
          state_d = o_tc ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wprec_q <= '0;
      iprec_q <= '0;
      len_q   <= '0;
      rows_q  <= '0;
      dbase_q <= '0;
      dptr_q  <= '0;
      optr_q  <= '0;
      wptr_q  <= '0;
      wrow_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wprec_q <= wprec_d;
      iprec_q <= iprec_d;
      len_q   <= len_d;
      rows_q  <= rows_d;
      dbase_q <= dbase_d;
      dptr_q  <= dptr_d;
      optr_q  <= optr_d;
      wptr_q  <= wptr_d;
      wrow_q  <= wrow_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign rdd_en   = (state_q == ST_ISSUE);
  assign wrd_en   = (state_q == ST_WRITE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign rdd_addr = dptr_q;
  assign rdw_addr = wptr_q;
  assign wrd_addr = optr_q;
  assign acc_clr  = issue && first;
  assign acc_sh   = issue && (k_cnt == '0) &&
                    !(ib_cnt == '0 && wb_cnt == '0);

`ifdef MVU_MAXPOOL_EN
  logic pool_q, pool_d;
  logic wfirst_q, wfirst_d;

  always_comb begin
    pool_d = pool_q;
    if (state_q == ST_IDLE && start) pool_d = cfg_pool_en;
    wfirst_d = (state_d == ST_WRITE) && (state_q != ST_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pool_q   <= 1'b0;
      wfirst_q <= 1'b0;
    end else begin
      pool_q   <= pool_d;
      wfirst_q <= wfirst_d;
    end
  end

  assign max_pool = busy && pool_q;
  assign max_en   = wrd_en && pool_q;
  assign max_clr  = wrd_en && pool_q && wfirst_q && (o_cnt == '0);
`else
  logic unused_pool;
  assign unused_pool = cfg_pool_en ^ (|o_cnt);
  assign max_pool    = 1'b0;
  assign max_en      = 1'b0;
  assign max_clr     = 1'b0;
`endif

endmodule

// File: tb/tb_mvu_job_ctrl.sv
// Self-checking bench for mvu_job_ctrl: vector table,
// directed corner sequences and random jobs vs. a loop model.
module tb_mvu_job_ctrl;

  localparam int LAT = 3;
  localparam bit POOL_BUILD =
`ifdef MVU_MAXPOOL_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    int wp, ip, len, rows;
    int wbase, dbase, obase, pool;
    int gmode, wdel, exp_iss, exp_wr;
  } vec_t;

  logic        clk = 0, rst_n = 0, start = 0;
  logic [3:0]  cfg_wprec = 0, cfg_iprec = 0;
  logic [9:0]  cfg_len = 0, cfg_rows = 0;
  logic [8:0]  cfg_wbase = 0;
  logic [13:0] cfg_dbase = 0, cfg_obase = 0;
  logic        cfg_pool_en = 0;
  logic        rdd_grnt = 0, wrd_grnt = 0;
  logic        rdd_en, acc_clr, acc_sh, wrd_en;
  logic        max_en, max_clr, max_pool, busy, done;
  logic [13:0] rdd_addr, wrd_addr;
  logic [8:0]  rdw_addr;
  logic [45:0] all_out;

  mvu_job_ctrl #(
    .BWBANKA(9), .BDBANKA(14), .BLEN(10), .BPREC(4), .LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_wprec(cfg_wprec), .cfg_iprec(cfg_iprec),
    .cfg_len(cfg_len), .cfg_rows(cfg_rows),
    .cfg_wbase(cfg_wbase), .cfg_dbase(cfg_dbase),
    .cfg_obase(cfg_obase), .cfg_pool_en(cfg_pool_en),
    .rdd_en(rdd_en), .rdd_grnt(rdd_grnt),
    .rdd_addr(rdd_addr), .rdw_addr(rdw_addr),
    .acc_clr(acc_clr), .acc_sh(acc_sh),
    .wrd_en(wrd_en), .wrd_grnt(wrd_grnt),
    .wrd_addr(wrd_addr), .max_en(max_en),
    .max_clr(max_clr), .max_pool(max_pool),
    .busy(busy), .done(done)
  );

  assign all_out = {rdd_en, rdd_addr, rdw_addr, acc_clr, acc_sh,
                    wrd_en, wrd_addr, max_en, max_clr, max_pool,
                    busy, done};

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int gmode = 0, wdel = 0, wwait = 0;
  int done_n, stall_n, hold_err, ctl_err, drain_err, max_err;
  int last_iss, wlen;
  bit hold_v, wr_act, job_pool;
  logic [13:0] hd;
  logic [8:0]  hw;
  logic [13:0] iss_d[$];
  logic [8:0]  iss_w[$];
  bit          iss_c[$], iss_s[$];
  logic [13:0] wr_a[$];
  int          wr_len[$];
  vec_t        vt[8];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Grant drivers
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (gmode)
        0:       rdd_grnt = 1'b1;
        1:       rdd_grnt = ($urandom % 4) != 0;
        default: rdd_grnt = !(iss_d.size() == 2 && stall_n < 3);
      endcase
      if (wrd_en) begin
        wrd_grnt = (wwait >= wdel);
        wwait++;
      end else begin
        wrd_grnt = 1'b0;
        wwait = 0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      bit pe;
      pe = POOL_BUILD && job_pool;
      if (rdd_en && rdd_grnt) begin
        if (hold_v && (rdd_addr !== hd || rdw_addr !== hw))
          hold_err++;
        hold_v = 0;
        iss_d.push_back(rdd_addr);
        iss_w.push_back(rdw_addr);
        iss_c.push_back(acc_clr);
        iss_s.push_back(acc_sh);
        last_iss = cyc;
      end else begin
        if (acc_clr || acc_sh) ctl_err++;
        if (rdd_en) begin
          if (hold_v && (rdd_addr !== hd || rdw_addr !== hw))
            hold_err++;
          hd = rdd_addr;
          hw = rdw_addr;
          hold_v = 1;
          stall_n++;
        end
      end
      if (rdd_en && wrd_en) ctl_err++;
      if (wrd_en) begin
        if (!wr_act && (cyc - last_iss != LAT + 1)) drain_err++;
        if (max_en !== pe) max_err++;
        if (max_clr !== (pe && !wr_act && wr_a.size() == 0))
          max_err++;
        wr_act = 1;
        wlen++;
        if (wrd_grnt) begin
          wr_a.push_back(wrd_addr);
          wr_len.push_back(wlen);
          wlen = 0;
          wr_act = 0;
        end
      end else if (max_en || max_clr) begin
        max_err++;
      end
      if (max_pool !== (busy && pe)) max_err++;
      if (done) done_n++;
    end
  end

  task automatic run_job(input vec_t v, input string nm);
    logic [13:0] md[$];
    logic [8:0]  mw[$];
    bit          mc[$], ms[$];
    logic [13:0] ma[$];
    int n;
    iss_d.delete(); iss_w.delete(); iss_c.delete();
    iss_s.delete(); wr_a.delete(); wr_len.delete();
    done_n = 0; stall_n = 0; hold_err = 0; ctl_err = 0;
    drain_err = 0; max_err = 0; hold_v = 0; wr_act = 0;
    wlen = 0; last_iss = 0;
    gmode = v.gmode; wdel = v.wdel; job_pool = (v.pool != 0);
    // Reference: nested loops straight from the address formulas
    for (int o = 0; o < v.rows && v.len > 0; o++) begin
      for (int wb = 0; wb <= v.wp; wb++)
        for (int ib = 0; ib <= v.ip; ib++)
          for (int k = 0; k < v.len; k++) begin
            md.push_back(14'(v.dbase + ib * v.len + k));
            mw.push_back(9'(v.wbase +
              (o * (v.wp + 1) + wb) * v.len + k));
            mc.push_back(wb == 0 && ib == 0 && k == 0);
            ms.push_back(k == 0 && (wb != 0 || ib != 0));
          end
      ma.push_back(14'(v.obase + o));
    end
    cfg_wprec = 4'(v.wp);      cfg_iprec = 4'(v.ip);
    cfg_len = 10'(v.len);      cfg_rows = 10'(v.rows);
    cfg_wbase = 9'(v.wbase);   cfg_dbase = 14'(v.dbase);
    cfg_obase = 14'(v.obase);  cfg_pool_en = v.pool[0];
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    cfg_wprec = 4'($urandom);  cfg_iprec = 4'($urandom);
    cfg_len = 10'($urandom);   cfg_rows = 10'($urandom);
    cfg_wbase = 9'($urandom);  cfg_dbase = 14'($urandom);
    cfg_obase = 14'($urandom); cfg_pool_en = ~cfg_pool_en;
    if (v.exp_iss > 0) chk({nm, " rdd_en_next"}, rdd_en, 1);
    else chk({nm, " done_next"}, done, 1);
    n = 0;
    while (busy && n < 4000) begin
      start = (n == 3);
      @(posedge clk);
      #1;
      n++;
    end
    start = 0;
    chk({nm, " finish"}, busy, 0);
    @(posedge clk);
    #1;
    chk({nm, " n_iss"}, iss_d.size(), v.exp_iss);
    chk({nm, " n_wr"}, wr_a.size(), v.exp_wr);
    chk({nm, " model_iss"}, md.size(), v.exp_iss);
    for (int i = 0; i < md.size() && i < iss_d.size(); i++)
      chk($sformatf("%s iss%0d", nm, i),
          {iss_d[i], iss_w[i], iss_c[i], iss_s[i]},
          {md[i], mw[i], mc[i], ms[i]});
    for (int i = 0; i < ma.size() && i < wr_a.size(); i++)
      chk($sformatf("%s wr%0d", nm, i), wr_a[i], ma[i]);
    chk({nm, " done_n"}, done_n, 1);
    chk({nm, " hold"}, hold_err, 0);
    chk({nm, " ctl"}, ctl_err, 0);
    chk({nm, " drain"}, drain_err, 0);
    chk({nm, " max"}, max_err, 0);
  endtask

  initial begin
    int e_d[6];
    int e_w[8];
    int e_x[4];
    vec_t r;
    vt[0] = '{0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 6, 2};
    vt[1] = '{1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 8, 1};
    vt[2] = '{0, 0, 4, 1, 510, 0, 0, 0, 0, 5, 4, 1};
    vt[3] = '{0, 0, 5, 0, 7, 9, 11, 1, 0, 0, 0, 0};
    vt[4] = '{2, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[5] = '{2, 1, 3, 2, 100, 16380, 16383, 1, 1, 2, 36, 2};
    vt[6] = '{0, 3, 1, 3, 0, 40, 5, 0, 1, 1, 12, 3};
    vt[7] = '{0, 0, 3, 2, 0, 0, 0, 0, 2, 0, 6, 2};
    e_d = '{0, 1, 2, 0, 1, 2};
    e_w = '{0, 1, 0, 1, 2, 3, 2, 3};
    e_x = '{510, 511, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", all_out, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_job(vt[i], $sformatf("vec%0d", i));
      case (i)
        0: begin
          for (int j = 0; j < 6; j++)
            chk($sformatf("seq24 %0d", j),
                {iss_d[j], iss_w[j], iss_c[j]},
                {14'(e_d[j]), 9'(j), 1'(j == 0 || j == 3)});
          chk("seq24 wr0", wr_a[0], 0);
          chk("seq24 wr1", wr_a[1], 1);
        end
        1: for (int j = 0; j < 8; j++)
          chk($sformatf("seq25 %0d", j),
              {iss_d[j], iss_w[j], iss_s[j]},
              {14'(j % 4), 9'(e_w[j]),
               1'(j == 2 || j == 4 || j == 6)});
        2: begin
          for (int j = 0; j < 4; j++)
            chk($sformatf("seq27 w%0d", j), iss_w[j], e_x[j]);
          chk("seq27 wr_hold", wr_len[0], 6);
        end
        7: chk("seq26 stalls", stall_n, 3);
        default: ;
      endcase
    end

    // Reset in the middle of an issue burst
    gmode = 0;
    cfg_len = 8; cfg_rows = 2; cfg_wprec = 0; cfg_iprec = 0;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst issuing", rdd_en, 1);
    #2;
    rst_n = 0;
    #1;
    chk("midrst outputs", all_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    run_job(vt[5], "post_rst");

    for (int t = 0; t < 25; t++) begin
      r.wp = $urandom % 4;        r.ip = $urandom % 4;
      r.len = $urandom % 7;       r.rows = $urandom % 5;
      r.wbase = $urandom % 512;   r.dbase = $urandom % 16384;
      r.obase = $urandom % 16384; r.pool = $urandom % 2;
      r.gmode = 1;                r.wdel = $urandom % 4;
      r.exp_iss = r.rows * (r.wp + 1) * (r.ip + 1) * r.len;
      r.exp_wr = (r.len == 0) ? 0 : r.rows;
      run_job(r, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
